mem_copy_engine: RTL and testbench
==================================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter ADDR_W, default 20, SHALL set address width of all address ports.
REQ-002 Parameter DATA_W, default 20, SHALL set data width of all data ports.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset, sampled on posedge clk.
REQ-005 start  input  1  SHALL request a copy; sampled only in IDLE.
REQ-006 src_addr  input  ADDR_W  SHALL be the first source word address.
REQ-007 dst_addr  input  ADDR_W  SHALL be the first destination word address.
REQ-008 length  input  6  SHALL be the word count; legal range 0..32.
REQ-009 busy  output  1  SHALL be high while a copy is in progress.
REQ-010 done  output  1  SHALL be a one-cycle pulse on copy completion.
REQ-011 error  output  1  SHALL be a one-cycle pulse on an illegal-length rejection.
REQ-012 mem_address  output  ADDR_W  SHALL be the data-memory word address.
REQ-013 mem_writeData  output  DATA_W  SHALL be the data-memory write data.
REQ-014 mem_memwrite  output  1  SHALL be the data-memory write strobe.
REQ-015 mem_memread  output  1  SHALL be the data-memory read strobe.
REQ-016 mem_memtoreg  output  1  SHALL hold the memory read path; must be 1 while read data is pending.
REQ-017 mem_readData  input  DATA_W  SHALL be the registered memory read data, valid the cycle after a mem_memread edge.

Function
REQ-018 The FSM SHALL have the states IDLE, RD, LAT, WR and FIN.
REQ-019 In IDLE, on start=1 with length in 1..32, the block SHALL latch src_addr, dst_addr and length, clear the word index i, and enter RD.
REQ-020 In IDLE, on start=1 with length=0, the block SHALL enter FIN with no memory strobe.
REQ-021 In IDLE, on start=1 with length>32, the block SHALL pulse error for the next cycle, stay in IDLE, and issue no strobe.
REQ-022 In RD, the block SHALL drive mem_memread=1, mem_memtoreg=1 and mem_address=src+i, then enter LAT.
REQ-023 In LAT, the block SHALL drive mem_memread=0 and mem_memtoreg=1, capture mem_readData into an internal buffer at the clock edge, then enter WR.
REQ-024 In WR, the block SHALL drive mem_memwrite=1, mem_address=dst+i and mem_writeData=buffer.
REQ-025 On leaving WR, the block SHALL enter RD with i+1 if i+1<length, else enter FIN.
REQ-026 In FIN, done SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-027 busy SHALL be 1 in RD, LAT and WR, and 0 in IDLE and FIN.
REQ-028 Latency: a copy of N≥1 words SHALL occupy 3N busy cycles, with done in the cycle immediately after the last WR.
REQ-029 Address arithmetic SHALL be modulo 2^ADDR_W; src+i and dst+i wrap silently.
REQ-030 Words SHALL be copied in ascending index order; an overlapping forward copy (dst>src) replicates the source pattern, and this is defined behaviour.
REQ-031 start asserted while busy or in FIN SHALL be ignored; latched parameters SHALL NOT change mid-copy.
REQ-032 mem_memread and mem_memwrite SHALL never be 1 in the same cycle.
REQ-033 mem_memtoreg SHALL be 1 in RD, LAT and WR, and 0 otherwise.
REQ-034 Outside WR, mem_memwrite SHALL be 0; outside RD, mem_memread SHALL be 0.
REQ-035 mem_address and mem_writeData SHALL be 0 in IDLE and FIN.

Reset
REQ-036 reset=1 at a clock edge SHALL force IDLE and clear the index, the buffer and the latched parameters.
REQ-037 After reset, busy, done, error, mem_memwrite, mem_memread, mem_memtoreg, mem_address and mem_writeData SHALL all be 0.
REQ-038 Reset asserted mid-copy SHALL abort the copy with no done pulse; words already written SHALL stay written, and no further strobe SHALL be issued.
REQ-039 reset SHALL take priority over start in the same cycle.

Verification
REQ-040 Memory preloaded mem[k]=k; start with src=2, dst=10, length=3 -> mem[10..12]=2,3,4; busy high for 9 cycles; done pulses in cycle 10 after start.
REQ-041 start with length=0 -> done pulses the cycle after start; busy stays 0; no mem_memread or mem_memwrite.
REQ-042 start with length=40 -> error pulses for 1 cycle; no strobes; the FSM stays in IDLE; a following legal start is accepted.
REQ-043 src=30, dst=0xFFFFE, length=4 -> mem_address sequence on reads 30,31,32,33 and on writes 0xFFFFE,0xFFFFF,0x00000,0x00001 (wrap).
REQ-044 reset asserted in the LAT state of word 2 of a 5-word copy -> the next cycle has all outputs 0 and no done; exactly 1 word written.
REQ-045 start pulsed again during a busy copy -> ignored; a single done pulse; the destination matches the first request only.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Memory-to-memory word copy engine.
// Copies `length` words from src_addr upward to dst_addr upward through a
// single-port data memory with one cycle of registered read latency.
// Each word takes three cycles: read request, read data capture, write.
module mem_copy_engine #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [5:0]        length,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_memwrite,
    output logic              mem_memread,
    output logic              mem_memtoreg,
    input  logic [DATA_W-1:0] mem_readData
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_LAT  = 3'd2,
        S_WR   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    localparam logic [5:0] MAX_LEN = 6'd32;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] src_reg;
    logic [ADDR_W-1:0] dst_reg;
    logic [5:0]        len_reg;
    logic [5:0]        idx_reg;
    logic [DATA_W-1:0] buf_reg;
    logic              error_reg;

    logic              len_zero;
    logic              len_legal;
    logic              len_illegal;
    logic              last_word;
    logic [ADDR_W-1:0] src_word_addr;
    logic [ADDR_W-1:0] dst_word_addr;

    // Length classification and per-word address arithmetic (wraps modulo 2^ADDR_W)
    assign len_zero      = (length == 6'd0);
    assign len_illegal   = (length > MAX_LEN);
    assign len_legal     = !len_zero && !len_illegal;
    assign last_word     = ((idx_reg + 6'd1) >= len_reg);
    assign src_word_addr = src_reg + ADDR_W'(idx_reg);
    assign dst_word_addr = dst_reg + ADDR_W'(idx_reg);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start is only looked at in IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (len_zero) begin
                        state_next = S_FIN;
                    end else if (len_legal) begin
                        state_next = S_RD;
                    end
                end
            end
            S_RD:    state_next = S_LAT;
            S_LAT:   state_next = S_WR;
            S_WR:    state_next = last_word ? S_FIN : S_RD;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: latch request parameters, capture read data, advance word index
    always_ff @(posedge clk) begin
        if (reset) begin
            src_reg   <= '0;
            dst_reg   <= '0;
            len_reg   <= '0;
            idx_reg   <= '0;
            buf_reg   <= '0;
            error_reg <= 1'b0;
        end else begin
            error_reg <= (state_reg == S_IDLE) && start && len_illegal;
            case (state_reg)
                S_IDLE: begin
                    if (start && len_legal) begin
                        src_reg <= src_addr;
                        dst_reg <= dst_addr;
                        len_reg <= length;
                        idx_reg <= '0;
                    end
                end
                S_LAT: begin
                    buf_reg <= mem_readData;
                end
                S_WR: begin
                    if (!last_word) begin
                        idx_reg <= idx_reg + 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state; address and write data are zero when not copying
    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        mem_address   = '0;
        mem_writeData = '0;
        mem_memwrite  = 1'b0;
        mem_memread   = 1'b0;
        mem_memtoreg  = 1'b0;
        case (state_reg)
            S_RD: begin
                busy         = 1'b1;
                mem_memread  = 1'b1;
                mem_memtoreg = 1'b1;
                mem_address  = src_word_addr;
            end
            S_LAT: begin
                busy         = 1'b1;
                mem_memtoreg = 1'b1;
                mem_address  = src_word_addr;
            end
            S_WR: begin
                busy          = 1'b1;
                mem_memtoreg  = 1'b1;
                mem_memwrite  = 1'b1;
                mem_address   = dst_word_addr;
                mem_writeData = buf_reg;
            end
            S_FIN: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign error = error_reg;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: a sparse memory model answers the
// engine's strobes, and an independent golden memory image predicts the result
// of every accepted copy as a plain ascending word-by-word assignment loop.
module tb_mem_copy_engine;

    localparam int AW = 20;
    localparam int DW = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [5:0]    length = '0;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_writeData;
    logic          mem_memwrite;
    logic          mem_memread;
    logic          mem_memtoreg;
    logic [DW-1:0] mem_readData = '0;

    int vectors = 0;
    int miscompares = 0;

    mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .mem_address  (mem_address),
        .mem_writeData(mem_writeData),
        .mem_memwrite (mem_memwrite),
        .mem_memread  (mem_memread),
        .mem_memtoreg (mem_memtoreg),
        .mem_readData (mem_readData)
    );

    always #5 clk = ~clk;

    // Sparse memories: an address never written holds its own address.
    logic [DW-1:0] mem  [logic [AW-1:0]];
    logic [DW-1:0] gold [logic [AW-1:0]];

    function automatic logic [DW-1:0] mrd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : DW'(a);
    endfunction

    function automatic logic [DW-1:0] grd(input logic [AW-1:0] a);
        return gold.exists(a) ? gold[a] : DW'(a);
    endfunction

    // Reference: ascending word copy over a wrapping address space
    function automatic void model_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
        for (int k = 0; k < n; k++) begin
            logic [AW-1:0] sa;
            logic [AW-1:0] da;
            sa = s + AW'(k);
            da = d + AW'(k);
            gold[da] = grd(sa);
        end
    endfunction

    // Data memory with registered read
    always @(posedge clk) begin
        if (mem_memwrite) mem[mem_address] = mem_writeData;
        if (mem_memread) mem_readData <= mrd(mem_address);
    end

    // Strobe monitor and output-protocol watcher
    logic          mon_en = 1'b0;
    int            rd_cnt = 0;
    int            wr_cnt = 0;
    int            prot_viol = 0;
    logic [AW-1:0] rd_q[$];
    logic [AW-1:0] wr_q[$];

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (mem_memread) begin
                rd_q.push_back(mem_address);
                rd_cnt++;
            end
            if (mem_memwrite) begin
                wr_q.push_back(mem_address);
                wr_cnt++;
            end
            if (mem_memread && mem_memwrite) prot_viol++;
            if (!busy && (mem_memtoreg || mem_memread || mem_memwrite ||
                          mem_address != '0 || mem_writeData != '0)) prot_viol++;
            if (busy && !mem_memtoreg) prot_viol++;
        end
    end

    function automatic void clear_mem();
        mem.delete();
        gold.delete();
    endfunction

    // Issue one start request and observe the engine until done (or budget out)
    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [5:0] n,
                            output int busy_cyc, output int done_cyc,
                            output int done_cnt, output int err_cnt);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        length   = n;
        start    = 1'b1;
        busy_cyc = 0;
        done_cyc = 0;
        done_cnt = 0;
        err_cnt  = 0;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy)  busy_cyc++;
            if (done)  begin done_cnt++; if (done_cyc == 0) done_cyc = c; end
            if (error) err_cnt++;
            if (done_cyc != 0 && c >= done_cyc + 3) break;
        end
        $display("copy src=%05h dst=%05h len=%0d : busy=%0d done@%0d dones=%0d errors=%0d",
                 s, d, n, busy_cyc, done_cyc, done_cnt, err_cnt);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        length = 6'd3;
        src_addr = 20'd5;
        dst_addr = 20'd9;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({busy, done, error, mem_memwrite, mem_memread, mem_memtoreg} !== 6'b0 ||
            mem_address !== '0 || mem_writeData !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b done=%b error=%b wr=%b rd=%b toreg=%b addr=%h wdata=%h, required all 0",
                     busy, done, error, mem_memwrite, mem_memread, mem_memtoreg, mem_address, mem_writeData);
        end
        start = 1'b0;
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_priority: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int b, dc, dn, e;
        clear_mem();
        model_copy(20'd2, 20'd10, 3);
        run_copy(20'd2, 20'd10, 6'd3, b, dc, dn, e);
        vectors++;
        if (b !== 9 || dc !== 10 || dn !== 1 || e !== 0) begin
            miscompares++;
            $display("FAIL basic_timing: busy=%0d done_cycle=%0d dones=%0d errors=%0d, required 9 10 1 0", b, dc, dn, e);
        end
        vectors++;
        if (mrd(20'd10) !== 20'd2 || mrd(20'd11) !== 20'd3 || mrd(20'd12) !== 20'd4) begin
            miscompares++;
            $display("FAIL basic_data: mem[10..12]=%0d,%0d,%0d, required 2,3,4",
                     mrd(20'd10), mrd(20'd11), mrd(20'd12));
        end
    endtask

    task automatic test_zero_length();
        int b, dc, dn, e, r0, w0;
        r0 = rd_cnt;
        w0 = wr_cnt;
        run_copy(20'd7, 20'd70, 6'd0, b, dc, dn, e);
        vectors++;
        if (b !== 0 || dc !== 1 || dn !== 1 || e !== 0 || rd_cnt !== r0 || wr_cnt !== w0) begin
            miscompares++;
            $display("FAIL zero_length: busy=%0d done_cycle=%0d dones=%0d errors=%0d reads=%0d writes=%0d, required 0 1 1 0 0 0",
                     b, dc, dn, e, rd_cnt - r0, wr_cnt - w0);
        end
    endtask

    task automatic test_illegal_length();
        int b, dc, dn, e, r0, w0;
        logic [5:0] n;
        for (int t = 0; t < 3; t++) begin
            n = (t == 0) ? 6'd40 : (t == 1) ? 6'd33 : 6'($urandom_range(34, 63));
            r0 = rd_cnt;
            w0 = wr_cnt;
            run_copy(20'd3, 20'd50, n, b, dc, dn, e);
            vectors++;
            if (e !== 1 || b !== 0 || dn !== 0 || rd_cnt !== r0 || wr_cnt !== w0) begin
                miscompares++;
                $display("FAIL illegal_len_%0d: errors=%0d busy=%0d dones=%0d reads=%0d writes=%0d, required 1 0 0 0 0",
                         n, e, b, dn, rd_cnt - r0, wr_cnt - w0);
            end
        end
        clear_mem();
        model_copy(20'd20, 20'd40, 2);
        run_copy(20'd20, 20'd40, 6'd2, b, dc, dn, e);
        vectors++;
        if (b !== 6 || dc !== 7 || dn !== 1 || mrd(20'd40) !== grd(20'd40) || mrd(20'd41) !== grd(20'd41)) begin
            miscompares++;
            $display("FAIL legal_after_error: busy=%0d done_cycle=%0d dones=%0d mem40=%0d mem41=%0d, required 6 7 1 20 21",
                     b, dc, dn, mrd(20'd40), mrd(20'd41));
        end
    endtask

    task automatic test_wrap();
        int b, dc, dn, e;
        logic [AW-1:0] exp_rd[4];
        logic [AW-1:0] exp_wr[4];
        int bad;
        exp_rd = '{20'd30, 20'd31, 20'd32, 20'd33};
        exp_wr = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
        clear_mem();
        rd_q.delete();
        wr_q.delete();
        model_copy(20'd30, 20'hFFFFE, 4);
        run_copy(20'd30, 20'hFFFFE, 6'd4, b, dc, dn, e);
        bad = 0;
        if (rd_q.size() != 4 || wr_q.size() != 4) bad = 1;
        else for (int k = 0; k < 4; k++) if (rd_q[k] !== exp_rd[k] || wr_q[k] !== exp_wr[k]) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL wrap_addresses: reads=%p writes=%p, required %p %p", rd_q, wr_q, exp_rd, exp_wr);
        end
        bad = 0;
        for (int k = 0; k < 4; k++) if (mrd(exp_wr[k]) !== grd(exp_wr[k])) bad++;
        vectors++;
        if (bad != 0 || dc !== 13) begin
            miscompares++;
            $display("FAIL wrap_data: bad_words=%0d done_cycle=%0d, required 0 13", bad, dc);
        end
    endtask

    task automatic test_reset_midcopy();
        int r0, w0, dn, bad;
        clear_mem();
        r0 = rd_cnt;
        w0 = wr_cnt;
        model_copy(20'd100, 20'd200, 1);
        @(negedge clk);
        src_addr = 20'd100;
        dst_addr = 20'd200;
        length = 6'd5;
        start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        vectors++;
        if (busy !== 1'b1 || mem_memtoreg !== 1'b1 || mem_memread !== 1'b0 || mem_memwrite !== 1'b0) begin
            miscompares++;
            $display("FAIL midcopy_lat_state: busy=%b toreg=%b rd=%b wr=%b, required 1 1 0 0",
                     busy, mem_memtoreg, mem_memread, mem_memwrite);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, done, error, mem_memwrite, mem_memread, mem_memtoreg} !== 6'b0 ||
            mem_address !== '0 || mem_writeData !== '0) begin
            miscompares++;
            $display("FAIL midcopy_abort_outputs: busy=%b done=%b rd=%b wr=%b addr=%h, required all 0",
                     busy, done, mem_memread, mem_memwrite, mem_address);
        end
        reset = 1'b0;
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        bad = 0;
        for (int k = 0; k < 5; k++) if (mrd(20'd200 + AW'(k)) !== grd(20'd200 + AW'(k))) bad++;
        vectors++;
        if (dn !== 0 || wr_cnt - w0 !== 1 || rd_cnt - r0 !== 2 || bad !== 0) begin
            miscompares++;
            $display("FAIL midcopy_abort_effect: activity=%0d writes=%0d reads=%0d bad_words=%0d, required 0 1 2 0",
                     dn, wr_cnt - w0, rd_cnt - r0, bad);
        end
    endtask

    task automatic test_start_while_busy();
        int b, dc, dn, bad;
        clear_mem();
        wr_q.delete();
        model_copy(20'd300, 20'd400, 4);
        @(negedge clk);
        src_addr = 20'd300;
        dst_addr = 20'd400;
        length = 6'd4;
        start = 1'b1;
        b = 0; dc = 0; dn = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (busy) b++;
            if (done) begin dn++; if (dc == 0) dc = c; end
            start = (c == 3 || c == 7 || c == 12 || c == 13);
            if (start) begin
                src_addr = 20'd500;
                dst_addr = 20'd600;
                length = 6'd6;
            end
        end
        $display("copy src=%05h dst=%05h len=4 with restarts : busy=%0d done@%0d dones=%0d", 20'd300, 20'd400, b, dc, dn);
        vectors++;
        if (b !== 12 || dc !== 13 || dn !== 1) begin
            miscompares++;
            $display("FAIL busy_restart_timing: busy=%0d done_cycle=%0d dones=%0d, required 12 13 1", b, dc, dn);
        end
        bad = 0;
        for (int k = 0; k < 4; k++) if (mrd(20'd400 + AW'(k)) !== grd(20'd400 + AW'(k))) bad++;
        for (int k = 0; k < 6; k++) if (mrd(20'd600 + AW'(k)) !== grd(20'd600 + AW'(k))) bad++;
        if (wr_q.size() != 4) bad++;
        else for (int k = 0; k < 4; k++) if (wr_q[k] !== 20'd400 + AW'(k)) bad++;
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL busy_restart_data: bad_items=%0d writes=%p, required 0", bad, wr_q);
        end
    endtask

    task automatic test_random();
        int b, dc, dn, e, r0, w0, bad, n;
        logic [AW-1:0] s, d;
        for (int t = 0; t < 12; t++) begin
            n = (t == 0) ? 32 : (t == 1) ? 1 : int'($urandom_range(1, 32));
            s = AW'($urandom);
            case ($urandom_range(0, 2))
                0:       d = s + AW'($urandom_range(1, 5));
                1:       d = s - AW'($urandom_range(1, 5));
                default: d = AW'($urandom);
            endcase
            r0 = rd_cnt;
            w0 = wr_cnt;
            model_copy(s, d, n);
            run_copy(s, d, 6'(n), b, dc, dn, e);
            vectors++;
            if (b !== 3 * n || dc !== 3 * n + 1 || dn !== 1 || e !== 0 ||
                rd_cnt - r0 !== n || wr_cnt - w0 !== n) begin
                miscompares++;
                $display("FAIL random_%0d_timing: busy=%0d done_cycle=%0d dones=%0d errors=%0d reads=%0d writes=%0d, required %0d %0d 1 0 %0d %0d",
                         t, b, dc, dn, e, rd_cnt - r0, wr_cnt - w0, 3 * n, 3 * n + 1, n, n);
            end
            bad = 0;
            for (int k = 0; k < n; k++) if (mrd(d + AW'(k)) !== grd(d + AW'(k))) bad++;
            vectors++;
            if (bad !== 0) begin
                miscompares++;
                $display("FAIL random_%0d_data: bad_words=%0d of %0d, required 0", t, bad, n);
            end
        end
    endtask

    task automatic test_protocol();
        vectors++;
        if (prot_viol !== 0) begin
            miscompares++;
            $display("FAIL output_protocol: violations=%0d, required 0", prot_viol);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_length();
        test_illegal_length();
        test_wrap();
        test_reset_midcopy();
        test_start_while_busy();
        test_random();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
